// File: rtl/vga_pkg.sv
// Shared definitions for the 1024x768 VGA test-pattern path.
// Holds the default timing limits, the pattern-select encodings, the
// debounce FSM state type and the mode wrap helper.
package vga_pkg;

  // Last horizontal/vertical counts of the 1024x768 @ 60 Hz timing
  localparam int unsigned H_LAST_1024 = 1343;
  localparam int unsigned V_LAST_1024 = 805;

  localparam int unsigned COORD_W  = 11;
  localparam int unsigned MODE_W   = 2;
  localparam int unsigned FRAME_W  = 8;
  localparam int unsigned DB_CNT_W = 20;

  // Pattern-select encodings understood by the pattern generator
  localparam logic [MODE_W-1:0] MODE_HSTRIPES = 2'd0;
  localparam logic [MODE_W-1:0] MODE_VSTRIPES = 2'd1;
  localparam logic [MODE_W-1:0] MODE_CHECKER  = 2'd2;
  localparam logic [MODE_W-1:0] MODE_SOLID    = 2'd3;

  typedef enum logic [1:0] {
    DB_IDLE       = 2'd0,
    DB_PRESS_WAIT = 2'd1,
    DB_HELD       = 2'd2,
    DB_REL_WAIT   = 2'd3
  } db_state_e;

  // Advance the pattern select, wrapping after the last implemented mode
  function automatic logic [MODE_W-1:0] next_mode(input logic [MODE_W-1:0] m,
                                                  input int unsigned       num_modes);
    if (m >= MODE_W'(num_modes - 1)) begin
      return MODE_HSTRIPES;
    end
    return m + MODE_W'(1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, then a press/release
// debounce FSM. Emits a single-cycle press pulse once the input has
// stayed high for DEBOUNCE_CYCLES cycles; release is debounced the same
// way but produces no pulse.
// Ports:
//   clk   - pixel clock
//   clr_n - asynchronous active-low reset
//   btn   - raw asynchronous button, active-high
//   press - registered one-cycle pulse per debounced press
module btn_debounce
  import vga_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 650000
) (
  input  logic clk,
  input  logic clr_n,
  input  logic btn,
  output logic press
);

  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                sync1_q;
  logic                sync2_q;
  db_state_e           state_q;
  db_state_e           state_d;
  logic [DB_CNT_W-1:0] cnt_q;
  logic [DB_CNT_W-1:0] cnt_d;
  logic                press_d;

  // Two-stage synchronizer for the asynchronous button
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  // FSM state, stability counter and press pulse registers
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= DB_IDLE;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press   <= press_d;
    end
  end

  // Next-state logic; the counter measures how long the input has been stable
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    case (state_q)
      DB_IDLE: begin
        if (sync2_q) begin
          state_d = DB_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      DB_PRESS_WAIT: begin
        if (!sync2_q) begin
          state_d = DB_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_HELD;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + DB_CNT_W'(1);
        end
      end
      DB_HELD: begin
        if (!sync2_q) begin
          state_d = DB_REL_WAIT;
          cnt_d   = '0;
        end
      end
      DB_REL_WAIT: begin
        if (sync2_q) begin
          state_d = DB_HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_IDLE;
        end else begin
          cnt_d = cnt_q + DB_CNT_W'(1);
        end
      end
      default: begin
        state_d = DB_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/vga_pattern_sequencer.sv
// Frame-synchronous test-pattern selector for the 1024x768 VGA path.
// Debounces a "next pattern" and an "auto-cycle toggle" button and
// applies every mode change on the last pixel of a frame, so each frame
// shows exactly one pattern.
// Ports:
//   clk          - 65 MHz pixel clock
//   clr_n        - asynchronous active-low reset
//   hc, vc       - horizontal/vertical counts from the timing generator
//   btn_next     - raw "next pattern" button, active-high
//   btn_auto     - raw auto-cycle toggle button, active-high
//   mode         - pattern select to the pattern generator
//   auto_en      - auto-cycle enabled
//   mode_changed - one-cycle pulse on the first pixel of a frame with a new mode
//   req_pending  - a manual advance is queued for the next frame boundary
module vga_pattern_sequencer
  import vga_pkg::*;
#(
  parameter int unsigned HLAST           = H_LAST_1024,
  parameter int unsigned VLAST           = V_LAST_1024,
  parameter int unsigned NUM_MODES       = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 650000,
  parameter int unsigned AUTO_FRAMES     = 120
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic [COORD_W-1:0] hc,
  input  logic [COORD_W-1:0] vc,
  input  logic               btn_next,
  input  logic               btn_auto,
  output logic [MODE_W-1:0]  mode,
  output logic               auto_en,
  output logic               mode_changed,
  output logic               req_pending
);

  logic               press_next;
  logic               press_auto;
  logic               eof_c;
  logic               auto_due_c;
  logic               advance_c;
  logic [FRAME_W-1:0] frame_cnt_q;
  logic [FRAME_W-1:0] frame_cnt_d;
  logic [MODE_W-1:0]  mode_d;
  logic               auto_en_d;
  logic               mode_changed_d;
  logic               req_pending_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_next (
    .clk  (clk),
    .clr_n(clr_n),
    .btn  (btn_next),
    .press(press_next)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_auto (
    .clk  (clk),
    .clr_n(clr_n),
    .btn  (btn_auto),
    .press(press_auto)
  );

  // Frame boundary, auto interval expiry and the single advance decision
  always_comb begin
    eof_c      = (hc == COORD_W'(HLAST)) && (vc == COORD_W'(VLAST));
    auto_due_c = auto_en && (frame_cnt_q == FRAME_W'(AUTO_FRAMES - 1)) && eof_c;
    advance_c  = eof_c && (req_pending || auto_due_c);
  end

  // Next values of the sequencer registers
  always_comb begin
    mode_d         = mode;
    auto_en_d      = auto_en;
    mode_changed_d = advance_c;
    req_pending_d  = req_pending;
    frame_cnt_d    = frame_cnt_q;

    if (advance_c) begin
      mode_d = next_mode(mode, NUM_MODES);
    end

    // A press on the boundary cycle survives the clear and waits a frame
    if (advance_c) begin
      req_pending_d = 1'b0;
    end
    if (press_next) begin
      req_pending_d = 1'b1;
    end

    if (press_auto) begin
      auto_en_d = ~auto_en;
    end

    // Any advance, manual or automatic, restarts the auto interval
    if (press_auto || advance_c) begin
      frame_cnt_d = '0;
    end else if (eof_c && auto_en) begin
      frame_cnt_d = frame_cnt_q + FRAME_W'(1);
    end
  end

  // Sequencer state and outputs
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      mode         <= MODE_HSTRIPES;
      auto_en      <= 1'b0;
      mode_changed <= 1'b0;
      req_pending  <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      mode         <= mode_d;
      auto_en      <= auto_en_d;
      mode_changed <= mode_changed_d;
      req_pending  <= req_pending_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Self-checking bench for vga_pattern_sequencer with a shrunken frame
// (10 x 5 pixels), 4-cycle debounce and a 3-frame auto interval.
module tb_vga_pattern_sequencer;

  localparam int unsigned HL = 9;
  localparam int unsigned VL = 4;
  localparam int unsigned DB = 4;
  localparam int unsigned AF = 3;
  localparam int unsigned NM = 4;

  logic        clk = 1'b0;
  logic        clr_n;
  logic [10:0] hc;
  logic [10:0] vc;
  logic        btn_next;
  logic        btn_auto;
  logic [1:0]  mode;
  logic        auto_en;
  logic        mode_changed;
  logic        req_pending;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  typedef struct {
    int         n_next;
    logic       do_auto;
    int         frames;
    logic [1:0] exp_mode;
    logic       exp_auto;
    int         exp_pulses;
  } vec_t;

  vec_t vecs[12];

  vga_pattern_sequencer #(
    .HLAST(HL),
    .VLAST(VL),
    .NUM_MODES(NM),
    .DEBOUNCE_CYCLES(DB),
    .AUTO_FRAMES(AF)
  ) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .hc          (hc),
    .vc          (vc),
    .btn_next    (btn_next),
    .btn_auto    (btn_auto),
    .mode        (mode),
    .auto_en     (auto_en),
    .mode_changed(mode_changed),
    .req_pending (req_pending)
  );

  always #5 clk = ~clk;

  // Free-running raster counter standing in for the timing generator
  initial begin
    hc = '0;
    vc = '0;
    forever begin
      @(posedge clk);
      #1;
      if (hc == 11'(HL)) begin
        hc = '0;
        vc = (vc == 11'(VL)) ? 11'd0 : vc + 11'd1;
      end else begin
        hc = hc + 11'd1;
      end
    end
  end

  // Every mode_changed pulse must sit on the first pixel of a frame
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (mode_changed === 1'b1) begin
        pulses++;
        checks++;
        if (!(hc == 11'd0 && vc == 11'd0)) begin
          errors++;
          $display("FAIL mode_changed_pos: pulse at hc=%0d vc=%0d, required hc=0 vc=0", hc, vc);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic wait_pos(input int h, input int v);
    int k = 0;
    step();
    while (!(hc == 11'(h) && vc == 11'(v)) && k < 200) begin
      step();
      k++;
    end
    if (!(hc == 11'(h) && vc == 11'(v))) begin
      checks++;
      errors++;
      $display("FAIL wait_pos_timeout: got hc=%0d vc=%0d, expected hc=%0d vc=%0d", hc, vc, h, v);
    end
  endtask

  task automatic to_frame_start();
    wait_pos(0, 0);
  endtask

  // 8 cycles high then 8 low: one debounced press with full release
  task automatic clean_press(input logic is_auto);
    if (is_auto) btn_auto = 1'b1;
    else         btn_next = 1'b1;
    step(8);
    btn_auto = 1'b0;
    btn_next = 1'b0;
    step(8);
  endtask

  initial begin
    int p0;

    // Scenario table: presses at a frame start, then wait whole frames
    vecs[0]  = '{3, 1'b0, 1, 2'd2, 1'b0, 1};  // three presses absorbed into one
    vecs[1]  = '{0, 1'b0, 2, 2'd2, 1'b0, 0};  // idle frames hold the mode
    vecs[2]  = '{1, 1'b0, 1, 2'd3, 1'b0, 1};
    vecs[3]  = '{3, 1'b0, 1, 2'd0, 1'b0, 1};  // wrap 3 -> 0, still one step
    vecs[4]  = '{0, 1'b1, 1, 2'd0, 1'b1, 0};  // auto on, first eof counts
    vecs[5]  = '{0, 1'b0, 1, 2'd0, 1'b1, 0};
    vecs[6]  = '{0, 1'b0, 1, 2'd1, 1'b1, 1};  // third eof advances
    vecs[7]  = '{0, 1'b0, 3, 2'd2, 1'b1, 1};
    vecs[8]  = '{0, 1'b0, 3, 2'd3, 1'b1, 1};
    vecs[9]  = '{0, 1'b0, 3, 2'd0, 1'b1, 1};  // auto wrap
    vecs[10] = '{0, 1'b1, 4, 2'd0, 1'b0, 0};  // auto off, frozen
    vecs[11] = '{1, 1'b0, 1, 2'd1, 1'b0, 1};

    clr_n    = 1'b0;
    btn_next = 1'b0;
    btn_auto = 1'b0;

    // Reset state
    step(3);
    chk("rst_mode", int'(mode), 0);
    chk("rst_auto_en", int'(auto_en), 0);
    chk("rst_mode_changed", int'(mode_changed), 0);
    chk("rst_req_pending", int'(req_pending), 0);
    clr_n = 1'b1;

    // Five quiet frames keep mode 0
    repeat (5) to_frame_start();
    chk("quiet_mode", int'(mode), 0);
    chk("quiet_pulses", pulses, 0);
    chk("quiet_req_pending", int'(req_pending), 0);

    // Bouncy press: high 2, low 1, high 10
    p0 = pulses;
    btn_next = 1'b1; step(2);
    btn_next = 1'b0; step(1);
    btn_next = 1'b1; step(3);
    chk("bounce_no_early_req", int'(req_pending), 0);
    step(7);
    chk("bounce_req_pending", int'(req_pending), 1);
    btn_next = 1'b0;
    step(10);
    chk("bounce_mode_before_eof", int'(mode), 0);
    to_frame_start();
    chk("bounce_mode_after_eof", int'(mode), 1);
    chk("bounce_mode_changed_first_pixel", int'(mode_changed), 1);
    chk("bounce_req_cleared", int'(req_pending), 0);
    step(1);
    chk("bounce_mode_changed_one_cycle", int'(mode_changed), 0);
    chk("bounce_pulses", pulses - p0, 1);
    to_frame_start();

    // Table-driven scenarios
    for (int i = 0; i < 12; i++) begin
      p0 = pulses;
      for (int j = 0; j < vecs[i].n_next; j++) clean_press(1'b0);
      if (vecs[i].do_auto) clean_press(1'b1);
      repeat (vecs[i].frames) to_frame_start();
      chk($sformatf("vec%0d_mode", i), int'(mode), int'(vecs[i].exp_mode));
      chk($sformatf("vec%0d_auto_en", i), int'(auto_en), int'(vecs[i].exp_auto));
      chk($sformatf("vec%0d_req_pending", i), int'(req_pending), 0);
      chk($sformatf("vec%0d_pulses", i), pulses - p0, vecs[i].exp_pulses);
    end

    // Collision: pending request lands on the auto-due boundary
    clean_press(1'b1);
    to_frame_start();
    chk("col_auto_on", int'(auto_en), 1);
    to_frame_start();
    chk("col_mode_hold", int'(mode), 1);
    p0 = pulses;
    clean_press(1'b0);
    to_frame_start();
    chk("col_single_step", int'(mode), 2);
    chk("col_pulses", pulses - p0, 1);
    chk("col_req_cleared", int'(req_pending), 0);

    // Manual advance restarts the auto interval
    clean_press(1'b0);
    to_frame_start();
    chk("restart_manual", int'(mode), 3);
    to_frame_start();
    to_frame_start();
    chk("restart_no_early_auto", int'(mode), 3);
    to_frame_start();
    chk("restart_auto_after_3", int'(mode), 0);

    // Auto off, then a press whose pulse coincides with eof
    clean_press(1'b1);
    to_frame_start();
    chk("eofpress_auto_off", int'(auto_en), 0);
    wait_pos(2, 4);
    btn_next = 1'b1;
    step(8);
    chk("eofpress_not_applied", int'(mode), 0);
    chk("eofpress_pending", int'(req_pending), 1);
    chk("eofpress_no_pulse", int'(mode_changed), 0);
    btn_next = 1'b0;
    to_frame_start();
    chk("eofpress_applied_next", int'(mode), 1);
    chk("eofpress_req_cleared", int'(req_pending), 0);

    // Mid-frame reset with btn_auto held through release
    clean_press(1'b0);
    wait_pos(5, 2);
    chk("pre_rst_mode", int'(mode), 1);
    chk("pre_rst_req", int'(req_pending), 1);
    btn_auto = 1'b1;
    clr_n    = 1'b0;
    #1;
    chk("midrst_mode", int'(mode), 0);
    chk("midrst_auto_en", int'(auto_en), 0);
    chk("midrst_mode_changed", int'(mode_changed), 0);
    chk("midrst_req_pending", int'(req_pending), 0);
    step(2);
    clr_n = 1'b1;
    step(4);
    chk("held_no_press_early", int'(auto_en), 0);
    step(3);
    chk("held_no_press_at_6", int'(auto_en), 0);
    step(1);
    chk("held_press_toggles", int'(auto_en), 1);
    step(40);
    chk("held_single_press", int'(auto_en), 1);
    btn_auto = 1'b0;
    step(20);
    chk("release_no_press", int'(auto_en), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
